// File: rtl/mem_preloader_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_preloader_if
// Brief    : Host byte stream, memory preload strobes and core-control bundle.
// Revision : 1.0
// ============================================================================
interface mem_preloader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [7:0]            s_data;
  logic                  preload_en_instr;
  logic                  preload_en_data;
  logic [ADDR_WIDTH-1:0] preload_addr;
  logic [DATA_WIDTH-1:0] preload_data;
  logic                  core_rst_n;
  logic                  done;
  logic                  error;

  // The loader is the master of the preload bus and the sink of the host stream.
  modport master (
    input  s_valid, s_data,
    output s_ready, preload_en_instr, preload_en_data, preload_addr, preload_data,
           core_rst_n, done, error
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, preload_en_instr, preload_en_data, preload_addr, preload_data,
           core_rst_n, done, error
  );
endinterface
`default_nettype wire

// File: rtl/mem_preloader.sv
`default_nettype none
// ============================================================================
// Module   : mem_preloader
// Brief    : Framed byte-stream loader writing instruction/data memory and
//            holding the core in reset until GO. Optional PRELOAD_CHECKSUM_EN
//            adds an XOR trailer byte to every I/D frame.
// Revision : 1.0
// ============================================================================
module mem_preloader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 1024
) (
  input  wire logic       clk,
  input  wire logic       areset_n,
  mem_preloader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [16:0] c_max_words = 17'(MAX_WORDS);
`ifdef PRELOAD_CHECKSUM_EN
  localparam state_e c_payload_end = ST_CHK;
`else
  localparam state_e c_payload_end = ST_IDLE;
`endif

  state_e                  state_q, state_d;
  logic                    alive_q;
  logic [2:0]              hdr_cnt_q, hdr_cnt_d;
  logic [31:0]             addr_hdr_q, addr_hdr_d;
  logic [7:0]              n_lo_q, n_lo_d;
  logic [15:0]             words_left_q, words_left_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-9:0]   word_q, word_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic                    sel_data_q, sel_data_d;
  logic                    en_instr_q, en_instr_d;
  logic                    en_data_q, en_data_d;
  logic [ADDR_WIDTH-1:0]   pl_addr_q, pl_addr_d;
  logic [DATA_WIDTH-1:0]   pl_data_q, pl_data_d;
`ifdef PRELOAD_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  logic        w_accepting;
  logic        w_hs;
  logic [15:0] w_n;

  always_comb begin
    w_accepting = 1'b0;
    case (state_q)
      ST_IDLE, ST_HDR, ST_DATA, ST_CHK: w_accepting = alive_q;
      default:                          w_accepting = 1'b0;
    endcase
  end

  assign w_hs = bus.s_valid && w_accepting;
  assign w_n  = {bus.s_data, n_lo_q};

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    addr_hdr_d   = addr_hdr_q;
    n_lo_d       = n_lo_q;
    words_left_d = words_left_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    cur_addr_d   = cur_addr_q;
    sel_data_d   = sel_data_q;
    en_instr_d   = 1'b0;
    en_data_d    = 1'b0;
    pl_addr_d    = pl_addr_q;
    pl_data_d    = pl_data_q;
`ifdef PRELOAD_CHECKSUM_EN
    csum_d       = w_hs ? (csum_q ^ bus.s_data) : csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (w_hs) begin
          hdr_cnt_d = 3'd0;
`ifdef PRELOAD_CHECKSUM_EN
          csum_d    = bus.s_data;
`endif
          case (bus.s_data)
            8'h49: begin
              sel_data_d = 1'b0;
              state_d    = ST_HDR;
            end
            8'h44: begin
              sel_data_d = 1'b1;
              state_d    = ST_HDR;
            end
            8'h47:   state_d = ST_RUN;
            default: state_d = ST_ERR;
          endcase
        end
      end

      ST_HDR: begin
        if (w_hs) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q < 3'd4) begin
            addr_hdr_d[{hdr_cnt_q[1:0], 3'b000} +: 8] = bus.s_data;
          end else if (hdr_cnt_q == 3'd4) begin
            n_lo_d = bus.s_data;
          end else begin
            words_left_d = w_n;
            byte_cnt_d   = 2'd0;
            cur_addr_d   = ADDR_WIDTH'(addr_hdr_q);
            if ({1'b0, w_n} > c_max_words) begin
              state_d = ST_ERR;
            end else if (w_n == 16'd0) begin
              state_d = c_payload_end;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (w_hs) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {bus.s_data, word_q[DATA_WIDTH-9:8]};
          // Fourth byte completes the little-endian word; strobe it next cycle.
          if (byte_cnt_q == 2'd3) begin
            en_instr_d   = !sel_data_q;
            en_data_d    = sel_data_q;
            pl_addr_d    = cur_addr_q;
            pl_data_d    = {bus.s_data, word_q};
            cur_addr_d   = cur_addr_q + ADDR_WIDTH'(4);
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) begin
              state_d = c_payload_end;
            end
          end
        end
      end

`ifdef PRELOAD_CHECKSUM_EN
      ST_CHK: begin
        if (w_hs) begin
          state_d = (bus.s_data == csum_q) ? ST_IDLE : ST_ERR;
        end
      end
`endif

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      alive_q      <= 1'b0;
      hdr_cnt_q    <= 3'd0;
      addr_hdr_q   <= '0;
      n_lo_q       <= '0;
      words_left_q <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      cur_addr_q   <= '0;
      sel_data_q   <= 1'b0;
      en_instr_q   <= 1'b0;
      en_data_q    <= 1'b0;
      pl_addr_q    <= '0;
      pl_data_q    <= '0;
`ifdef PRELOAD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alive_q      <= 1'b1;
      hdr_cnt_q    <= hdr_cnt_d;
      addr_hdr_q   <= addr_hdr_d;
      n_lo_q       <= n_lo_d;
      words_left_q <= words_left_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      cur_addr_q   <= cur_addr_d;
      sel_data_q   <= sel_data_d;
      en_instr_q   <= en_instr_d;
      en_data_q    <= en_data_d;
      pl_addr_q    <= pl_addr_d;
      pl_data_q    <= pl_data_d;
`ifdef PRELOAD_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.s_ready          = w_accepting;
  assign bus.preload_en_instr = en_instr_q;
  assign bus.preload_en_data  = en_data_q;
  assign bus.preload_addr     = pl_addr_q;
  assign bus.preload_data     = pl_data_q;
  assign bus.core_rst_n       = (state_q == ST_RUN);
  assign bus.done             = (state_q == ST_RUN);
  assign bus.error            = (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_preloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_preloader
// Brief    : Randomised frame-level bench for mem_preloader; honours
//            PRELOAD_CHECKSUM_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_mem_preloader;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 1024;

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] data;
    int          pos;
  } wr_t;

  logic clk      = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  mem_preloader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_preloader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          hs_count = 0;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  wr_t         mon_w;
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (areset_n && bus.s_valid && bus.s_ready) hs_count <= hs_count + 1;
  end

  // Record every strobe together with the number of bytes accepted so far.
  always @(negedge clk) begin
    if (bus.preload_en_instr && bus.preload_en_data) check("dual_strobe", 1, 0);
    if (bus.preload_en_instr || bus.preload_en_data) begin
      mon_w.is_data = bus.preload_en_data;
      mon_w.addr    = bus.preload_addr;
      mon_w.data    = bus.preload_data;
      mon_w.pos     = hs_count;
      obs_q.push_back(mon_w);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.s_ready) check("hs_timeout", bus.s_ready, 1);
    else              @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Reference: a frame's writes follow directly from its header and payload.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input int n, input bit corrupt, input int max_gap);
    logic [7:0]  fb[$];
    logic [15:0] nf;
    logic [7:0]  x;
    wr_t         w;
    int          start;
    start = hs_count;
    nf    = 16'(n);
    fb    = {};
    fb.push_back(cmd);
    for (int i = 0; i < 4; i++) fb.push_back(addr[8*i +: 8]);
    fb.push_back(nf[7:0]);
    fb.push_back(nf[15:8]);
    if (n <= MAXW) begin
      while (words.size() < n) words.push_back($urandom);
      for (int k = 0; k < n; k++) begin
        for (int b = 0; b < 4; b++) fb.push_back(words[k][8*b +: 8]);
        w.is_data = (cmd == 8'h44);
        w.addr    = addr + 32'(4 * k);
        w.data    = words[k];
        w.pos     = start + 11 + 4 * k;
        exp_q.push_back(w);
      end
`ifdef PRELOAD_CHECKSUM_EN
      x = 8'h00;
      foreach (fb[i]) x = x ^ fb[i];
      if (corrupt) x = x ^ 8'h5A;
      fb.push_back(x);
`else
      x = {7'd0, corrupt};
`endif
    end
    foreach (fb[i]) send_byte(fb[i], $urandom_range(0, max_gap));
    words = {};
  endtask

  task automatic compare_writes(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_mem"},  obs_q[i].is_data, exp_q[i].is_data);
      check({tag, "_addr"}, obs_q[i].addr,    exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data,    exp_q[i].data);
      check({tag, "_pos"},  obs_q[i].pos,     exp_q[i].pos);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n    = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cmd;
    logic [31:0] a;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state
    @(negedge clk);
    areset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready",  bus.s_ready, 0);
    check("rst_en_instr", bus.preload_en_instr, 0);
    check("rst_en_data",  bus.preload_en_data, 0);
    check("rst_addr",     bus.preload_addr, 0);
    check("rst_data",     bus.preload_data, 0);
    check("rst_core",     bus.core_rst_n, 0);
    check("rst_done",     bus.done, 0);
    check("rst_error",    bus.error, 0);
    areset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.s_ready, 1);

    // Directed instruction frame
    words = {32'h0000_0513, 32'h0010_0093};
    send_frame(8'h49, 32'h0000_0100, 2, 1'b0, 0);
    compare_writes("t2");

    // Wrapping data frame, then random frames
    send_frame(8'h44, 32'hFFFF_FFFC, 2, 1'b0, 1);
    compare_writes("t3_wrap");
    for (int f = 0; f < 10; f++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'h49 : 8'h44;
      a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      send_frame(cmd, a, $urandom_range(0, 5), 1'b0, 2);
      compare_writes("t3_rand");
    end
    check("pre_go_error", bus.error, 0);
    check("pre_go_core",  bus.core_rst_n, 0);
    check("pre_go_ready", bus.s_ready, 1);
    send_byte(8'h47, 0);
    check("go_core",  bus.core_rst_n, 1);
    check("go_done",  bus.done, 1);
    check("go_ready", bus.s_ready, 0);
    check("go_error", bus.error, 0);

    // Bad command, then ignored GO
    do_reset();
    send_byte(8'h55, 0);
    check("badcmd_error", bus.error, 1);
    check("badcmd_ready", bus.s_ready, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h47;
    repeat (5) @(negedge clk);
    bus.s_valid = 1'b0;
    check("err_go_core",  bus.core_rst_n, 0);
    check("err_go_done",  bus.done, 0);
    check("err_sticky",   bus.error, 1);
    compare_writes("t4_nowr");

    // Largest legal word count, then one beyond it
    do_reset();
    send_frame(8'h44, $urandom, MAXW, 1'b0, 0);
    compare_writes("t4_maxw");
    check("maxw_error", bus.error, 0);
    send_frame(8'h49, 32'h0000_2000, MAXW + 1, 1'b0, 0);
    check("over_error", bus.error, 1);
    check("over_ready", bus.s_ready, 0);
    compare_writes("t4_over");

    // Reset in the middle of a word
    do_reset();
    send_byte(8'h49, 0);
    send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    do_reset();
    compare_writes("t5_abort");
    send_frame(8'h49, 32'h0000_0040, 3, 1'b0, 1);
    compare_writes("t5_reload");
    check("t5_error", bus.error, 0);

`ifdef PRELOAD_CHECKSUM_EN
    do_reset();
    send_frame(8'h49, 32'h0000_0080, 1, 1'b0, 0);
    compare_writes("t6_good");
    check("csum_ok_error", bus.error, 0);
    check("csum_ok_ready", bus.s_ready, 1);
    send_frame(8'h44, 32'h0000_0084, 0, 1'b0, 0);
    compare_writes("t6_n0");
    check("csum_n0_error", bus.error, 0);
    send_frame(8'h44, 32'h0000_0084, 1, 1'b1, 0);
    compare_writes("t6_bad");
    check("csum_bad_error", bus.error, 1);
    check("csum_bad_ready", bus.s_ready, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
